// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the LEGv8 fetch / branch pre-decode slice.
package fetch_pkg;

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [5:0] OPC_B   = 6'b000101;
    localparam logic [7:0] OPC_CBZ = 8'b10110100;

    localparam int IMM26_W = 26;
    localparam int IMM19_W = 19;

endpackage

// File: rtl/branch_decode.sv
// Combinational pre-decode of B / CBZ into branch flags and a sign-extended word offset.
module branch_decode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic        branchFlag,
    output logic        unconditionalBranchFlag,
    output logic [31:0] pcOffsetFilled
);

    logic signed [IMM26_W-1:0] imm26;
    logic signed [IMM19_W-1:0] imm19;

    assign imm26 = instr[IMM26_W-1:0];
    assign imm19 = instr[5 +: IMM19_W];

    always_comb begin
        branchFlag              = 1'b0;
        unconditionalBranchFlag = 1'b0;
        pcOffsetFilled          = 32'd0;
        if (instr[31:26] == OPC_B) begin
            unconditionalBranchFlag = 1'b1;
            pcOffsetFilled          = {{(32-IMM26_W){imm26[IMM26_W-1]}}, imm26};
        end else if (instr[31:24] == OPC_CBZ) begin
            branchFlag     = 1'b1;
            pcOffsetFilled = {{(32-IMM19_W){imm19[IMM19_W-1]}}, imm19};
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch over a req/ack memory handshake with registered branch pre-decode.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_start,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              branchFlag,
    output logic              unconditionalBranchFlag,
    output logic [31:0]       pcOffsetFilled,
    output logic              fault
);

    localparam int             TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] timer;

    logic        decBranch;
    logic        decUncond;
    logic [31:0] decOffset;

    branch_decode uDecode (
        .instr                  (mem_rdata),
        .branchFlag             (decBranch),
        .unconditionalBranchFlag(decUncond),
        .pcOffsetFilled         (decOffset)
    );

    // mem_req and busy follow the state register, so reset drops them asynchronously.
    assign mem_req = (state == REQ);
    assign busy    = (state == REQ);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            timer                   <= '0;
            mem_addr                <= '0;
            instr                   <= '0;
            instr_valid             <= 1'b0;
            branchFlag              <= 1'b0;
            unconditionalBranchFlag <= 1'b0;
            pcOffsetFilled          <= '0;
            fault                   <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        if (PC[1:0] == 2'b00) begin
                            mem_addr <= PC;
                            timer    <= '0;
                            state    <= REQ;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A same-cycle ack wins over the timeout.
                    if (mem_ack) begin
                        instr                   <= mem_rdata;
                        branchFlag              <= decBranch;
                        unconditionalBranchFlag <= decUncond;
                        pcOffsetFilled          <= decOffset;
                        instr_valid             <= 1'b1;
                        state                   <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        fault <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized self-checking bench for fetch_decode against a behavioural fetch/decode model.
module tb_fetch_decode;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] PC = '0;
    logic        fetch_start = 1'b0;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        branchFlag;
    logic        unconditionalBranchFlag;
    logic [31:0] pcOffsetFilled;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // Reference state: what the unit should be presenting.
    logic [31:0] expInstr = '0;
    logic        expBr = 1'b0;
    logic        expUnc = 1'b0;
    logic [31:0] expOff = '0;

    fetch_decode #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .PC                     (PC),
        .fetch_start            (fetch_start),
        .busy                   (busy),
        .mem_req                (mem_req),
        .mem_addr               (mem_addr),
        .mem_ack                (mem_ack),
        .mem_rdata              (mem_rdata),
        .instr                  (instr),
        .instr_valid            (instr_valid),
        .branchFlag             (branchFlag),
        .unconditionalBranchFlag(unconditionalBranchFlag),
        .pcOffsetFilled         (pcOffsetFilled),
        .fault                  (fault)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Decode from the ISA rules: opcode field values and two's-complement immediates.
    function automatic void refDecode(input logic [31:0] w, output logic br, output logic unc,
                                      output logic [31:0] off);
        longint v;
        br = 1'b0; unc = 1'b0; off = '0;
        if ((w >> 26) == 32'd5) begin
            unc = 1'b1;
            v = longint'(w & 32'h03FF_FFFF);
            if (v >= 64'sh200_0000) v = v - 64'sh400_0000;
            off = v[31:0];
        end else if ((w >> 24) == 32'hB4) begin
            br = 1'b1;
            v = longint'((w >> 5) & 32'h7_FFFF);
            if (v >= 64'sh4_0000) v = v - 64'sh8_0000;
            off = v[31:0];
        end
    endfunction

    task automatic checkOutputs(input string tag);
        checkVal({tag, ".instr"}, instr, expInstr);
        checkVal({tag, ".br"}, {31'd0, branchFlag}, {31'd0, expBr});
        checkVal({tag, ".unc"}, {31'd0, unconditionalBranchFlag}, {31'd0, expUnc});
        checkVal({tag, ".off"}, pcOffsetFilled, expOff);
    endtask

    // Called #1 after a posedge; issues fetch_start now, acks after idleCycles REQ cycles.
    task automatic doFetch(input string tag, input logic [31:0] pc, input logic [31:0] word,
                           input int idleCycles);
        fetch_start = 1'b1;
        PC = pc;
        @(posedge clock); #1;
        fetch_start = 1'b0;
        PC = $urandom;
        checkVal({tag, ".req"}, {31'd0, mem_req}, 32'd1);
        checkVal({tag, ".busy"}, {31'd0, busy}, 32'd1);
        checkVal({tag, ".addr"}, mem_addr, pc);
        for (int i = 0; i < idleCycles; i++) begin
            mem_rdata = $urandom;
            @(posedge clock); #1;
            checkVal({tag, ".waitReq"}, {31'd0, mem_req}, 32'd1);
            checkVal({tag, ".waitVld"}, {31'd0, instr_valid}, 32'd0);
        end
        mem_ack = 1'b1;
        mem_rdata = word;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        expInstr = word;
        refDecode(word, expBr, expUnc, expOff);
        checkVal({tag, ".vld"}, {31'd0, instr_valid}, 32'd1);
        checkVal({tag, ".reqLow"}, {31'd0, mem_req}, 32'd0);
        checkVal({tag, ".busyLow"}, {31'd0, busy}, 32'd0);
        checkOutputs(tag);
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 2))
            0: w[31:26] = 6'b000101;
            1: w[31:24] = 8'hB4;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int n;
        logic sawVld;
        logic reqHeld;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkVal("rst.req", {31'd0, mem_req}, 32'd0);
        checkVal("rst.busy", {31'd0, busy}, 32'd0);
        checkVal("rst.addr", mem_addr, 32'd0);
        checkVal("rst.vld", {31'd0, instr_valid}, 32'd0);
        checkVal("rst.fault", {31'd0, fault}, 32'd0);
        checkOutputs("rst");
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Zero-wait B +3, then back-to-back ADD clears the flags, then CBZ -1 with delay
        doFetch("zeroB", 32'h40, 32'h1400_0003, 0);
        checkVal("zeroB.offConst", pcOffsetFilled, 32'h0000_0003);
        doFetch("add", 32'h44, 32'h8B02_0020, 0);
        checkVal("add.uncConst", {31'd0, unconditionalBranchFlag}, 32'd0);
        doFetch("cbzNeg", 32'h48, 32'hB4FF_FFE0, 2);
        checkVal("cbzNeg.offConst", pcOffsetFilled, 32'hFFFF_FFFF);
        // Ack on the last possible cycle wins over the timeout
        doFetch("ackLast", 32'h100, 32'h17FF_FFFF, TIMEOUT - 1);
        checkVal("ackLast.fault", {31'd0, fault}, 32'd0);
        @(posedge clock); #1;

        // Timeout with fetch_start held high throughout REQ
        fetch_start = 1'b1;
        PC = 32'h200;
        @(posedge clock); #1;
        PC = 32'h300;
        n = 0;
        sawVld = 1'b0;
        reqHeld = 1'b1;
        while (n < 40) begin
            if (!mem_req) reqHeld = 1'b0;
            @(posedge clock); #1;
            n++;
            if (instr_valid) sawVld = 1'b1;
            if (fault) break;
        end
        fetch_start = 1'b0;
        checkVal("tmo.cycles", n, TIMEOUT);
        checkVal("tmo.fault", {31'd0, fault}, 32'd1);
        checkVal("tmo.reqHeld", {31'd0, reqHeld}, 32'd1);
        checkVal("tmo.reqLow", {31'd0, mem_req}, 32'd0);
        checkVal("tmo.noVld", {31'd0, sawVld}, 32'd0);
        checkVal("tmo.addr", mem_addr, 32'h200);
        checkOutputs("tmo");
        @(posedge clock); #1;
        checkVal("tmo.pulse", {31'd0, fault}, 32'd0);
        checkVal("tmo.noRestart", {31'd0, mem_req}, 32'd0);

        // Misaligned PC
        fetch_start = 1'b1;
        PC = 32'h42;
        @(posedge clock); #1;
        fetch_start = 1'b0;
        checkVal("mis.fault", {31'd0, fault}, 32'd1);
        checkVal("mis.req", {31'd0, mem_req}, 32'd0);
        checkVal("mis.busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        checkVal("mis.pulse", {31'd0, fault}, 32'd0);
        checkVal("mis.req2", {31'd0, mem_req}, 32'd0);
        checkOutputs("mis");

        // Randomized fetches with random wait states and idle gaps
        for (int k = 0; k < 40; k++) begin
            logic [31:0] pc;
            int waits;
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            waits = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
            doFetch("rnd", pc, randWord(), waits);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        // Reset in the middle of a fetch, then a late ack
        fetch_start = 1'b1;
        PC = 32'h80;
        @(posedge clock); #1;
        fetch_start = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        expInstr = '0; expBr = 1'b0; expUnc = 1'b0; expOff = '0;
        checkVal("arst.req", {31'd0, mem_req}, 32'd0);
        checkVal("arst.busy", {31'd0, busy}, 32'd0);
        checkVal("arst.addr", mem_addr, 32'd0);
        checkOutputs("arst");
        mem_ack = 1'b1;
        mem_rdata = 32'h1400_0003;
        @(posedge clock); #1;
        reset_n = 1'b1;
        sawVld = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (instr_valid) sawVld = 1'b1;
        end
        mem_ack = 1'b0;
        checkVal("arst.noVld", {31'd0, sawVld}, 32'd0);
        checkVal("arst.reqIdle", {31'd0, mem_req}, 32'd0);
        checkOutputs("arst.late");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
